// File: rtl/module_frequency_divider_pkg.sv
// module_frequency_divider_pkg: shared widths, output reset level and delay FSM states.
package module_frequency_divider_pkg;
  localparam int DEF_PERIOD_W = 30;
  localparam int DEF_LIMIT_W = 8;
  localparam logic OUT_RST = 1'b0;
  typedef enum logic {IDLE, WAIT} dly_state_t;
endpackage

// File: rtl/freq_div_core.sv
// freq_div_core: square wave that toggles every half_period qzt_clk cycles.
module freq_div_core
  import module_frequency_divider_pkg::*;
#(
  parameter int W = DEF_PERIOD_W
) (
  input  logic         qzt_clk,
  input  logic         reset_n,
  input  logic [W-1:0] half_period,
  output logic         clk_out
);
  logic [W-1:0] cnt;
  logic [W:0] nxt;
  // cnt+1 >= half_period equals cnt >= half_period-1 without underflow at 0
  assign nxt = {1'b0, cnt} + 1'b1;
  always_ff @(posedge qzt_clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      clk_out <= OUT_RST;
    end else if (nxt >= {1'b0, half_period}) begin
      cnt <= '0;
      clk_out <= ~clk_out;
    end else cnt <= nxt[W-1:0];
endmodule

// File: rtl/module_frequency_divider.sv
// module_frequency_divider: main divided clock, timing tick, and a tick-delayed copy of the main clock.
module module_frequency_divider
  import module_frequency_divider_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int LIMIT_W = DEF_LIMIT_W
) (
  input  logic                qzt_clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] tick_period,
  input  logic [LIMIT_W-1:0]  limit,
  output logic                clk_out,
  output logic                tick_out,
  output logic                clk_delayed
);
  logic clk_prev, tick_prev, captured, clk_edge, tick_rise;
  logic [LIMIT_W-1:0] count;
  logic [LIMIT_W:0] count_nxt;
  dly_state_t state;
  freq_div_core #(.W(PERIOD_W)) u_main (
    .qzt_clk(qzt_clk), .reset_n(reset_n), .half_period(period), .clk_out(clk_out)
  );
  freq_div_core #(.W(PERIOD_W)) u_tick (
    .qzt_clk(qzt_clk), .reset_n(reset_n), .half_period(tick_period), .clk_out(tick_out)
  );
  assign clk_edge = clk_out != clk_prev;
  assign tick_rise = tick_out & ~tick_prev;
  assign count_nxt = {1'b0, count} + 1'b1;
  // a clk_edge always wins over a tick_rise and restarts any pending transition
  always_ff @(posedge qzt_clk or negedge reset_n)
    if (!reset_n) begin
      clk_prev <= 1'b0;
      tick_prev <= 1'b0;
      captured <= 1'b0;
      count <= '0;
      state <= IDLE;
      clk_delayed <= OUT_RST;
    end else begin
      clk_prev <= clk_out;
      tick_prev <= tick_out;
      if (clk_edge) begin
        captured <= clk_out;
        count <= '0;
        state <= (limit == '0) ? IDLE : WAIT;
        if (limit == '0) clk_delayed <= clk_out;
      end else if (state == WAIT && tick_rise) begin
        if (count_nxt == {1'b0, limit}) begin
          clk_delayed <= captured;
          state <= IDLE;
        end else if (!count_nxt[LIMIT_W]) count <= count_nxt[LIMIT_W-1:0];
      end
    end
endmodule

// File: tb/tb_module_frequency_divider.sv
// tb_module_frequency_divider: randomized and directed runs checked against an edge-index reference model.
module tb_module_frequency_divider;
  logic qzt_clk = 1'b0;
  logic reset_n = 1'b0;
  logic [29:0] period = 30'd2000;
  logic [29:0] tick_period = 30'd25;
  logic [7:0] limit = 8'd10;
  logic clk_out, tick_out, clk_delayed;
  int n_cmp = 0;
  int n_bad = 0;
  module_frequency_divider dut (
    .qzt_clk(qzt_clk), .reset_n(reset_n), .period(period), .tick_period(tick_period),
    .limit(limit), .clk_out(clk_out), .tick_out(tick_out), .clk_delayed(clk_delayed)
  );
  always #10 qzt_clk = ~qzt_clk;
  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask
  // async reset mid-cycle, verify immediate clearing, release at a negedge so the next posedge is edge 1
  task automatic do_reset();
    @(posedge qzt_clk);
    #5 reset_n = 1'b0;
    #1;
    check("rst_clk_out", clk_out, 1'b0);
    check("rst_tick_out", tick_out, 1'b0);
    check("rst_clk_delayed", clk_delayed, 1'b0);
    @(negedge qzt_clk);
    @(negedge qzt_clk);
    reset_n = 1'b1;
  endtask
  // Reference: outputs as functions of edge index k. Transition m of clk_out happens at m*pe,
  // is captured at c=m*pe+1, and lands on the lim-th tick rise detected after c (tick rises at
  // odd multiples of te, detected one edge later), unless the next capture arrives first.
  task automatic run(input int p, input int tp, input int lim, input int n);
    longint pe, te, c, j, d, a;
    bit ev[longint];
    bit del;
    period = 30'(p);
    tick_period = 30'(tp);
    limit = 8'(lim);
    pe = (p < 2) ? 1 : p;
    te = (tp < 2) ? 1 : tp;
    for (longint m = 1; m * pe + 1 <= n; m++) begin
      c = m * pe + 1;
      if (lim == 0) a = c;
      else begin
        j = (c + te - 1) / te;
        if (j % 2 == 0) j++;
        j += 2 * (lim - 1);
        d = j * te + 1;
        a = (d < c + pe) ? d : -1;
      end
      if (a > 0) ev[a] = bit'(m % 2);
    end
    do_reset();
    del = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge qzt_clk);
      @(negedge qzt_clk);
      if (ev.exists(k)) del = ev[k];
      check("clk_out", clk_out, logic'((k / pe) % 2));
      check("tick_out", tick_out, logic'((k / te) % 2));
      check("clk_delayed", clk_delayed, del);
    end
  endtask
  initial begin
    run(2000, 25, 10, 5000);
    run(2000, 25, 10, 2300);
    run(2000, 25, 10, 4600);
    run(2000, 25, 0, 4200);
    run(20, 25, 10, 2000);
    run(0, 1, 1, 200);
    for (int r = 0; r < 8; r++)
      run(int'($urandom_range(300, 0)), int'($urandom_range(30, 0)), int'($urandom_range(5, 0)), 3000);
    period = 30'd2000;
    tick_period = 30'd25;
    limit = 8'd10;
    do_reset();
    for (int k = 1; k <= 800; k++) begin
      @(posedge qzt_clk);
      @(negedge qzt_clk);
      check("period_change", clk_out, (k < 501) ? 1'b0 : logic'(((k - 501) / 100 + 1) % 2));
      if (k == 500) period = 30'd100;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/module_frequency_divider.md
# module_frequency_divider

Clock-generation block that derives two slow square waves from the board quartz clock: a main divided clock and a fast timing tick. It also produces a copy of the main divided clock whose transitions are delayed by a programmable number of tick periods. It sits between the 50 MHz quartz clock and peripheral interfaces that need a slow clock plus a phase-shifted companion, such as the mouse interface.

## Interface
Parameters:
- PERIOD_W, 30: width of the half-period inputs.
- LIMIT_W, 8: width of the delay count.

Ports:
- qzt_clk  input  1  quartz clock, the only clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- period  input  PERIOD_W  half-period of clk_out, in qzt_clk cycles.
- tick_period  input  PERIOD_W  half-period of tick_out, in qzt_clk cycles.
- limit  input  LIMIT_W  delay of clk_delayed, in tick_out rising edges.
- clk_out  output  1  main divided clock, registered.
- tick_out  output  1  timing tick square wave, registered.
- clk_delayed  output  1  clk_out with each transition delayed, registered.

## Operation
- Reset (asynchronous, reset_n=0):
  - All counters are 0.
  - clk_out, tick_out and clk_delayed are 0.
  - All edge-detect registers, the captured level and the pending flag are 0.
- Divider, identical for the main clock and the tick:
  - Counter cnt runs in qzt_clk cycles.
  - On each edge: if cnt >= half_period-1, toggle the output and set cnt to 0; otherwise increment cnt.
  - half_period of 0 or 1 toggles the output every cycle.
  - A change of half_period takes effect at the next compare. The `>=` compare means a reduced value wraps at once.
  - Output frequency = f_qzt / (2·half_period).
- Delay unit:
  - clk_out and tick_out are sampled by qzt_clk and compared with registered copies of themselves (clk_prev, tick_prev).
  - clk_edge = clk_out != clk_prev. tick_rise = tick_out & ~tick_prev.
  - On clk_edge: store captured ← clk_out, set count ← 0, set pending ← 1. A tick_rise in the same cycle is ignored.
  - If clk_edge occurs and limit = 0: set clk_delayed ← clk_out in that same cycle and keep pending at 0.
  - While pending, on tick_rise: if count+1 == limit, set clk_delayed ← captured and clear pending; otherwise increment count.
  - A new clk_edge while pending restarts the capture. The earlier, not-yet-applied transition is dropped.
  - The limit value is sampled every cycle. If limit is lowered below count, the transition is not applied until the next clk_edge. This is the intended behaviour.

## Timing
- Edge k is the k-th qzt_clk rising edge after reset_n deasserts.
- clk_out toggles at edges period, 2·period, and so on. tick_out behaves the same way with tick_period.
- Edge-detect latency is 1 cycle: a clk_out change at edge n is captured at edge n+1.
- clk_delayed latency from capture is the limit-th subsequent tick_rise. The tick is detected 1 cycle after tick_out rises.
- Delay range is roughly (limit−1)·T_tick to limit·T_tick, plus 1–2 qzt cycles.
- For correct output, the clk_out half-period must exceed the delay; otherwise transitions are lost.

## Structure
- Shared package holds PERIOD_W and LIMIT_W, plus the reset level of the outputs (0).
- One sub-module, freq_div_core (inputs: qzt_clk, reset_n, half_period; output: clk_out), instantiated twice: once for the main clock, once for the tick.
- Edge detection and the delay FSM live in the top, with two states: IDLE (pending=0) and WAIT (pending=1).

## Test plan
- Reset, with period=2000, tick_period=25, limit=10 and a 20 ns qzt_clk:
  - All outputs are 0.
  - tick_out rises at edges 25, 75, 125, … with a 1 µs period.
  - clk_out rises at edge 2000 and falls at edge 4000, giving 12.5 kHz.
- Same settings:
  - clk_delayed rises at edge 2476 and falls at edge 4476.
  - It repeats with an 80 µs period and is never high while clk_out has been low since before edge 4000.
- limit=0 → clk_delayed follows clk_out one cycle late: rises at edge 2001, falls at edge 4001.
- period=20, tick_period=25, limit=10 (delay greater than half-period) → pending is re-armed at every clk_edge and clk_delayed stays 0.
- reset_n pulsed low mid-delay (at edge 2300) → all outputs go to 0 immediately; after release, the sequence restarts from edge 1 exactly as in the first scenario.
- period changed from 2000 to 100 while cnt=500 → clk_out toggles on the next edge, then every 100 cycles.
